updown_mod_counter: RTL and testbench

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter.sv | 78 +++++++
 tb/tb_updown_mod_counter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo-(MAX+1) counter with clear/load, terminal-count flag,
// single-cycle wrap pulse and sticky boundary flag; wraps or saturates at bounds.
module updown_mod_counter #(
   parameter int          WIDTH    = 4,
   parameter int unsigned MAX      = 15,
   parameter int          SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic [WIDTH-1:0] count_p1;
   logic             wrap_p1;
   logic             ovf_p1;
   logic             at_top_p0;
   logic             at_bot_p0;
   logic             bnd_p0;

   // Loaded values above MAX are clamped so count never leaves 0..MAX.
   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
      return (v > MAX_V) ? MAX_V : v;
   endfunction

   // +1/-1 only happens strictly inside the range, so no carry can escape WIDTH bits.
   function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] c,
                                                   input logic             dir);
      if (dir) begin
         if (c == MAX_V)
            return (SATURATE != 0) ? c : '0;
         return c + WIDTH'(1);
      end
      if (c == '0)
         return (SATURATE != 0) ? c : MAX_V;
      return c - WIDTH'(1);
   endfunction

   // Stage p0: boundary detection on the current count and controls
   assign at_top_p0 = (count_p1 == MAX_V);
   assign at_bot_p0 = (count_p1 == '0);
   assign bnd_p0    = en & ~clr & ~load & ((up & at_top_p0) | (~up & at_bot_p0));

   // Stage p1: registered count and flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_p1 <= '0;
         wrap_p1  <= 1'b0;
         ovf_p1   <= 1'b0;
      end else if (clr) begin
         count_p1 <= '0;
         wrap_p1  <= 1'b0;
         ovf_p1   <= 1'b0;
      end else begin
         wrap_p1 <= bnd_p0;
         ovf_p1  <= ovf_p1 | bnd_p0;
         if (load)
            count_p1 <= clamp_load(load_val);
         else if (en)
            count_p1 <= step_count(count_p1, up);
      end
   end

   assign count = count_p1;
   assign tc    = bnd_p0;
   assign wrap  = wrap_p1;
   assign ovf   = ovf_p1;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomised bench for updown_mod_counter: five parameter variants share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_updown_mod_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
   logic [3:0] lv = '0;
   logic       chk_on = 1'b0;

   logic [3:0] cnt0, cnt1, cnt2, cnt3;
   logic [2:0] cnt4;
   logic [4:0] tcv, wrv, ovv;

   int errors = 0;
   int checks = 0;

   // Variant table: 0 wrap MAX=9, 1 saturate MAX=9, 2 wrap MAX=15, 3 wrap MAX=0, 4 saturate W=3 MAX=5
   int mx[5]  = '{9, 9, 15, 0, 5};
   int sat[5] = '{0, 1, 0, 0, 1};
   int msk[5] = '{15, 15, 15, 15, 7};
   int mc[5], mw[5], mo[5];

   always #5 clk = ~clk;

   updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(0)) u0 (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(lv),
      .count(cnt0), .tc(tcv[0]), .wrap(wrv[0]), .ovf(ovv[0]));
   updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1)) u1 (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(lv),
      .count(cnt1), .tc(tcv[1]), .wrap(wrv[1]), .ovf(ovv[1]));
   updown_mod_counter #(.WIDTH(4), .MAX(15), .SATURATE(0)) u2 (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(lv),
      .count(cnt2), .tc(tcv[2]), .wrap(wrv[2]), .ovf(ovv[2]));
   updown_mod_counter #(.WIDTH(4), .MAX(0), .SATURATE(0)) u3 (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(lv),
      .count(cnt3), .tc(tcv[3]), .wrap(wrv[3]), .ovf(ovv[3]));
   updown_mod_counter #(.WIDTH(3), .MAX(5), .SATURATE(1)) u4 (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(lv[2:0]),
      .count(cnt4), .tc(tcv[4]), .wrap(wrv[4]), .ovf(ovv[4]));

   // Behavioural reference: counting in plain integers modulo (MAX+1)
   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 5; k++) begin
         if (rst || clr) begin
            mc[k] = 0; mw[k] = 0; mo[k] = 0;
         end else if (load) begin
            int v;
            v = int'(lv) & msk[k];
            mc[k] = (v > mx[k]) ? mx[k] : v;
            mw[k] = 0;
         end else if (en) begin
            int nxt;
            nxt = up ? mc[k] + 1 : mc[k] - 1;
            if (nxt > mx[k] || nxt < 0) begin
               mw[k] = 1; mo[k] = 1;
               if (sat[k] == 0) mc[k] = up ? 0 : mx[k];
            end else begin
               mw[k] = 0;
               mc[k] = nxt;
            end
         end else begin
            mw[k] = 0;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every variant against the model
   always @(negedge clk) begin
      if (chk_on) begin
         int dc[5];
         int et;
         dc = '{int'(cnt0), int'(cnt1), int'(cnt2), int'(cnt3), int'(cnt4)};
         for (int k = 0; k < 5; k++) begin
            et = (en && !clr && !load &&
                  ((up && mc[k] == mx[k]) || (!up && mc[k] == 0))) ? 1 : 0;
            checks += 4;
            if (dc[k] !== mc[k]) begin
               errors++; $display("FAIL count[%0d]: got %0d expected %0d at %0t", k, dc[k], mc[k], $time);
            end
            if (int'(tcv[k]) !== et) begin
               errors++; $display("FAIL tc[%0d]: got %0d expected %0d at %0t", k, tcv[k], et, $time);
            end
            if (int'(wrv[k]) !== mw[k]) begin
               errors++; $display("FAIL wrap[%0d]: got %0d expected %0d at %0t", k, wrv[k], mw[k], $time);
            end
            if (int'(ovv[k]) !== mo[k]) begin
               errors++; $display("FAIL ovf[%0d]: got %0d expected %0d at %0t", k, ovv[k], mo[k], $time);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int exp_up[12]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      int exp_dn[9]    = '{6, 5, 4, 3, 2, 1, 0, 9, 8};

      #1 rst = 1'b1;
      tick();
      chk("reset_count", int'(cnt0), 0);
      chk("reset_wrap", int'(wrv[0]), 0);
      chk("reset_ovf", int'(ovv[0]), 0);
      rst = 1'b0;
      chk_on = 1'b1;

      // Count up through the wrap
      en = 1'b1; up = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("up_count", int'(cnt0), exp_up[i]);
         chk("up_wrap", int'(wrv[0]), (i == 9) ? 1 : 0);
         chk("up_tc", int'(tcv[0]), (exp_up[i] == 9) ? 1 : 0);
      end
      chk("up_ovf", int'(ovv[0]), 1);
      chk("max0_count", int'(cnt3), 0);
      chk("max0_wrap", int'(wrv[3]), 1);

      // Load 7 (over a pending enable), then count down through the wrap
      load = 1'b1; lv = 4'd7; up = 1'b0;
      tick();
      chk("load7", int'(cnt0), 7);
      load = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("dn_count", int'(cnt0), exp_dn[i]);
         chk("dn_wrap", int'(wrv[0]), (i == 7) ? 1 : 0);
      end

      // Saturating variant holds at 9
      load = 1'b1; lv = 4'd8; up = 1'b1;
      tick();
      chk("sat_load8", int'(cnt1), 8);
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("sat_count", int'(cnt1), 9);
         chk("sat_wrap", int'(wrv[1]), (i >= 1) ? 1 : 0);
      end
      chk("sat_ovf", int'(ovv[1]), 1);

      // Over-range load clamps; clear beats load
      en = 1'b0; load = 1'b1; lv = 4'd13;
      tick();
      chk("clamp_w0", int'(cnt0), 9);
      chk("clamp_w1", int'(cnt1), 9);
      clr = 1'b1;
      tick();
      chk("clr_count", int'(cnt0), 0);
      chk("clr_ovf", int'(ovv[0]), 0);
      clr = 1'b0;

      // Async reset mid-cycle with count=5, ovf=1
      lv = 4'd9;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      tick();
      chk("pre_rst_wrap", int'(wrv[0]), 1);
      en = 1'b0; load = 1'b1; lv = 4'd5;
      tick();
      chk("pre_rst_count", int'(cnt0), 5);
      chk("pre_rst_ovf", int'(ovv[0]), 1);
      load = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("async_count", int'(cnt0), 0);
      chk("async_ovf", int'(ovv[0]), 0);
      chk("async_wrap", int'(wrv[0]), 0);
      rst = 1'b0;

      // Full-range variant wraps 15 -> 0
      load = 1'b1; lv = 4'd15;
      tick();
      chk("full_load15", int'(cnt2), 15);
      load = 1'b0; en = 1'b1; up = 1'b1;
      tick();
      chk("full_wrap_count", int'(cnt2), 0);
      chk("full_wrap_pulse", int'(wrv[2]), 1);

      // Random phase with sticky direction to reach the bounds often
      for (int n = 0; n < 3000; n++) begin
         clr  = ($urandom_range(0, 99) < 3);
         load = ($urandom_range(0, 99) < 8);
         en   = ($urandom_range(0, 9) < 8);
         if ($urandom_range(0, 9) < 2) up = ~up;
         lv   = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 199) == 0) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
         end
         tick();
      end

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
